set_mode_controller: RTL and testbench
======================================

Name: set_mode_controller

Overview:
- Sequences the clock's time datapath: the current-time counter set and the alarm-time counter set.
- A 7-state mode FSM steers 1 s ticks and debounced add presses into per-unit increment strobes (sec/min/hour) for either counter set.
- Drives carry enable, display source select and digit-flash enables.
- Returns to run mode on an inactivity timeout, and optionally auto-repeats a held add button.
- Sits between the debouncers/1 s timer and the two time counters plus the display path.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency; documents the REPEAT_* defaults only.
- TIMEOUT_S, 10, number of tick_1s pulses of inactivity in a set state before the FSM forces RUN; 0 disables the timeout.
- REPEAT_DELAY, 25_000_000, clk cycles add_level must be held before auto-repeat starts.
- REPEAT_PERIOD, 5_000_000, clk cycles between auto-repeat strobes.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- tick_1s  in  1  one-cycle pulse, once per second.
- set_pulse  in  1  one-cycle pulse, debounced set button rising edge.
- add_pulse  in  1  one-cycle pulse, debounced add button rising edge.
- add_level  in  1  debounced add button level; used only with the optional feature.
- cur_inc  out  3  increment strobes to the current-time counter, bit0 = sec, bit1 = min, bit2 = hour.
- alm_inc  out  3  increment strobes to the alarm-time counter, same bit order.
- carry_en  out  1  allows sec->min->hour carry in the current-time counter.
- show_alarm  out  1  display source: 1 = alarm time, 0 = current time.
- flash  out  3  digit-pair flash enables, bit0 = sec, bit1 = min, bit2 = hour.
- mode  out  3  current state code, for status display and debug.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). All outputs are registered.
- Reset values: mode = RUN, cur_inc = 0, alm_inc = 0, carry_en = 1, show_alarm = 0, flash = 0, all counters = 0.
- States and codes: RUN = 0, CUR_SEC = 1, CUR_MIN = 2, CUR_HOUR = 3, ALM_SEC = 4, ALM_MIN = 5, ALM_HOUR = 6. Code 7 is illegal and recovers to RUN on the next clock.
- Transitions:
  - set_pulse advances to the next code.
  - ALM_HOUR + set_pulse -> RUN.
  - If set_pulse and add_pulse arrive in the same cycle, the add is applied in the current state and the set is dropped.
- RUN:
  - tick_1s produces cur_inc[0] one cycle later.
  - add_pulse is ignored.
  - carry_en = 1.
- Set states:
  - tick_1s produces no increment strobe; time is frozen while setting.
  - carry_en = 0.
  - add_pulse (or a repeat strobe) raises the unit's bit one cycle later, for exactly one cycle: CUR_x drives cur_inc, ALM_x drives alm_inc.
- Output decode, registered from the next state so it aligns with mode:
  - show_alarm = 1 in the ALM_* states.
  - flash bit = the unit being set (CUR_SEC/ALM_SEC -> bit0, etc.).
- Timeout:
  - An inactivity counter counts tick_1s while in a set state.
  - It clears on set_pulse, add_pulse, a repeat strobe, and on entry to any state.
  - When it reaches TIMEOUT_S and the next tick arrives, the FSM goes to RUN, with no increment on that tick.
- Strobes are mutually exclusive: at most one bit of {cur_inc, alm_inc} is high in any cycle.
- A reset during any state, including mid-repeat, returns to RUN with outputs zeroed on the next edge.

Optional Feature:
- Macro: SET_AUTO_REPEAT_EN.
- When defined, in a set state with add_level held:
  - After REPEAT_DELAY cycles of continuous hold (counted from the add_pulse), one strobe is emitted.
  - Further strobes follow every REPEAT_PERIOD cycles while held.
  - Releasing add_level, a state change, or rst clears the repeat counters.
  - Repeat strobes behave exactly like add_pulse, including clearing the timeout.
- When undefined: add_level is unused, there is no repeat logic, and each press gives exactly one increment.

Decomposition:
- Shared header clock_defs.vh holds:
  - the state code localparams RUN..ALM_HOUR;
  - the unit bit indices SEC = 0, MIN = 1, HOUR = 2;
  - the default CLK_HZ.
- One sub-module, add_repeat_gen (inside SET_AUTO_REPEAT_EN):
  - inputs clk, rst, enable, add_pulse, add_level;
  - output a rpt_pulse strobe;
  - parameters REPEAT_DELAY, REPEAT_PERIOD.

Test Plan:
- Reset, then 3 tick_1s pulses in RUN -> 3 single-cycle cur_inc = 3'b001, each one cycle after its tick; carry_en = 1, flash = 0.
- 4 set_pulses -> mode steps 1, 2, 3, 4. At mode 4: show_alarm = 1, flash = 3'b001. An add_pulse there -> alm_inc = 3'b001 for one cycle. tick_1s in that state -> no strobe.
- 7 set_pulses from RUN -> mode returns to 0; simultaneous set_pulse + add_pulse in CUR_MIN -> cur_inc = 3'b010, mode stays 2.
- TIMEOUT_S = 3: enter CUR_HOUR with no activity -> mode = 0 after the 4th tick. The same sequence with an add_pulse after tick 2 -> still in CUR_HOUR after tick 4.
- SET_AUTO_REPEAT_EN, REPEAT_DELAY = 10, REPEAT_PERIOD = 4: hold add_level for 30 cycles in CUR_SEC -> 1 press strobe + repeats at hold cycles 10, 14, 18, 22, 26, 30 (6 repeats). Without the macro -> 1 strobe only.
- Assert rst mid-repeat in ALM_MIN -> next edge: mode = 0, all strobes 0, show_alarm = 0, carry_en = 1.

Source files
------------

// File: rtl/set_mode_controller_pkg.sv
// Shared definitions for the set/mode controller.
//   mode_e          : state codes RUN = 0 .. ALM_HOUR = 6 (code 7 is illegal)
//   SEC/MIN/HOUR    : bit indices into the cur_inc/alm_inc/flash vectors
//   CLK_HZ_DEFAULT  : default system clock, sets the auto-repeat timing defaults
//   unit_mask()     : one-hot unit bit for a set state, 0 for RUN
//   is_alarm()      : true in the ALM_* states
//   next_mode()     : state reached on set_pulse
package set_mode_controller_pkg;

   typedef enum logic [2:0] {
      StRun     = 3'd0,
      StCurSec  = 3'd1,
      StCurMin  = 3'd2,
      StCurHour = 3'd3,
      StAlmSec  = 3'd4,
      StAlmMin  = 3'd5,
      StAlmHour = 3'd6
   } mode_e;

   localparam int unsigned SEC  = 0;
   localparam int unsigned MIN  = 1;
   localparam int unsigned HOUR = 2;

   localparam int unsigned CLK_HZ_DEFAULT = 50_000_000;

   function automatic logic [2:0] unit_mask(input mode_e m);
      logic [2:0] mask;
      mask = 3'b000;
      case (m)
         StCurSec,  StAlmSec:  mask[SEC]  = 1'b1;
         StCurMin,  StAlmMin:  mask[MIN]  = 1'b1;
         StCurHour, StAlmHour: mask[HOUR] = 1'b1;
         default:              mask = 3'b000;
      endcase
      return mask;
   endfunction

   function automatic logic is_alarm(input mode_e m);
      return (m == StAlmSec) || (m == StAlmMin) || (m == StAlmHour);
   endfunction

   function automatic mode_e next_mode(input mode_e m);
      if (m == StAlmHour) begin
         return StRun;
      end
      return mode_e'(m + 3'd1);
   endfunction

endpackage

// File: rtl/add_repeat_gen.sv
// Auto-repeat strobe generator for a held add button.
// Armed by add_pulse while enabled; after REPEAT_DELAY cycles of continuous hold it
// emits one rpt_pulse, then one every REPEAT_PERIOD cycles while add_level stays high.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   enable     : low clears all repeat state (not in a set state, or state changing)
//   add_pulse  : debounced press edge, (re)starts the hold timing
//   add_level  : debounced button level, release clears the repeat state
//   rpt_pulse  : one-cycle repeat strobe (combinational from registered state)
module add_repeat_gen #(
   parameter int unsigned REPEAT_DELAY  = 25_000_000,
   parameter int unsigned REPEAT_PERIOD = 5_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic add_pulse,
   input  logic add_level,
   output logic rpt_pulse
);

   localparam int unsigned MaxCnt = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned CntW   = (MaxCnt > 1) ? $clog2(MaxCnt + 1) : 1;

   // cnt_q holds the number of cycles since the press or the last repeat strobe
   logic [CntW-1:0] cnt_q;
   logic            armed_q;
   logic            rep_q;   // first repeat already emitted, use the period
   logic [CntW-1:0] target;

   assign target    = rep_q ? CntW'(REPEAT_PERIOD) : CntW'(REPEAT_DELAY);
   assign rpt_pulse = armed_q && add_level && !add_pulse && (cnt_q == target);

   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         armed_q <= 1'b0;
         rep_q   <= 1'b0;
         cnt_q   <= '0;
      end else if (add_pulse) begin
         armed_q <= 1'b1;
         rep_q   <= 1'b0;
         cnt_q   <= CntW'(1);
      end else if (armed_q && !add_level) begin
         armed_q <= 1'b0;
         rep_q   <= 1'b0;
         cnt_q   <= '0;
      end else if (rpt_pulse) begin
         rep_q   <= 1'b1;
         cnt_q   <= CntW'(1);
      end else if (armed_q) begin
         cnt_q   <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/set_mode_controller.sv
// Mode sequencer for the clock's current-time and alarm-time counter sets.
// Steers 1 s ticks (RUN) or add presses (set states) into per-unit increment strobes,
// and drives carry enable, display source select and digit-flash enables. A set state
// with TIMEOUT_S idle ticks falls back to RUN on the following tick (0 disables this).
// Optional feature macro: SET_AUTO_REPEAT_EN (auto-repeat while add_level is held).
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   tick_1s     : 1 s pulse
//   set_pulse   : set button edge, advances the mode
//   add_pulse   : add button edge, increments the unit being set
//   add_level   : add button level (auto-repeat only)
//   cur_inc     : current-time increment strobes {hour, min, sec}
//   alm_inc     : alarm-time increment strobes {hour, min, sec}
//   carry_en    : sec->min->hour carry allowed (RUN only)
//   show_alarm  : display shows the alarm time
//   flash       : digit-pair flash enables {hour, min, sec}
//   mode        : current state code
module set_mode_controller
   import set_mode_controller_pkg::*;
#(
   parameter int unsigned CLK_HZ        = CLK_HZ_DEFAULT,
   parameter int unsigned TIMEOUT_S     = 10,
   parameter int unsigned REPEAT_DELAY  = CLK_HZ / 2,
   parameter int unsigned REPEAT_PERIOD = CLK_HZ / 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1s,
   input  logic       set_pulse,
   input  logic       add_pulse,
   input  logic       add_level,
   output logic [2:0] cur_inc,
   output logic [2:0] alm_inc,
   output logic       carry_en,
   output logic       show_alarm,
   output logic [2:0] flash,
   output logic [2:0] mode
);

   localparam int unsigned TmoW = (TIMEOUT_S > 1) ? $clog2(TIMEOUT_S + 1) : 1;

   mode_e           state_q, state_d;
   logic [TmoW-1:0] tmo_q, tmo_d;
   logic [2:0]      cur_inc_d, alm_inc_d;
   logic            add_ev;
   logic            rpt_pulse;

   // CLK_HZ only sets the REPEAT_* defaults
   logic unused_clk_hz;
   assign unused_clk_hz = CLK_HZ[0];

`ifdef SET_AUTO_REPEAT_EN
   logic rpt_enable;

   // Dropping enable for the transition cycle clears the repeat state on any mode change
   assign rpt_enable = (state_q != StRun) && (state_d == state_q);

   add_repeat_gen #(
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
   ) u_add_repeat_gen (
      .clk       (clk),
      .rst       (rst),
      .enable    (rpt_enable),
      .add_pulse (add_pulse),
      .add_level (add_level),
      .rpt_pulse (rpt_pulse)
   );
`else
   logic unused_rpt_cfg;
   assign unused_rpt_cfg = add_level ^ REPEAT_DELAY[0] ^ REPEAT_PERIOD[0];
   assign rpt_pulse      = 1'b0;
`endif

   assign mode = state_q;

   always_comb begin
      state_d   = state_q;
      tmo_d     = tmo_q;
      cur_inc_d = 3'b000;
      alm_inc_d = 3'b000;
      add_ev    = add_pulse | rpt_pulse;

      case (state_q)
         StRun: begin
            if (tick_1s) begin
               cur_inc_d[SEC] = 1'b1;
            end
            // A simultaneous add wins over set, even though RUN ignores the add
            if (set_pulse && !add_pulse) begin
               state_d = StCurSec;
            end
         end
         StCurSec, StCurMin, StCurHour, StAlmSec, StAlmMin, StAlmHour: begin
            if (add_ev) begin
               if (is_alarm(state_q)) begin
                  alm_inc_d = unit_mask(state_q);
               end else begin
                  cur_inc_d = unit_mask(state_q);
               end
               tmo_d = '0;
            end else if (set_pulse) begin
               state_d = next_mode(state_q);
            end else if (tick_1s && (TIMEOUT_S != 0)) begin
               if (tmo_q == TmoW'(TIMEOUT_S)) begin
                  state_d = StRun;
               end else begin
                  tmo_d = tmo_q + 1'b1;
               end
            end
         end
         default: state_d = StRun;
      endcase

      // Idle count only lives inside one set state
      if ((state_d != state_q) || (state_q == StRun)) begin
         tmo_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StRun;
         tmo_q      <= '0;
         cur_inc    <= 3'b000;
         alm_inc    <= 3'b000;
         carry_en   <= 1'b1;
         show_alarm <= 1'b0;
         flash      <= 3'b000;
      end else begin
         state_q    <= state_d;
         tmo_q      <= tmo_d;
         cur_inc    <= cur_inc_d;
         alm_inc    <= alm_inc_d;
         // Decoded from the next state so these line up with mode
         carry_en   <= (state_d == StRun);
         show_alarm <= is_alarm(state_d);
         flash      <= unit_mask(state_d);
      end
   end

endmodule

// File: tb/tb_set_mode_controller.sv
// Bench for set_mode_controller: directed stimulus, a cycle-level behavioural model
// checked on every cycle, plus literal expectations at key points.
`timescale 1ns/1ps
module tb_set_mode_controller;

   localparam int unsigned TMO = 3;
   localparam int unsigned RD  = 10;
   localparam int unsigned RP  = 4;
`ifdef SET_AUTO_REPEAT_EN
   localparam bit RPT_EN = 1'b1;
   localparam int unsigned HOLD_STROBES = 7;
`else
   localparam bit RPT_EN = 1'b0;
   localparam int unsigned HOLD_STROBES = 1;
`endif

   logic       clk = 1'b0;
   logic       rst, tick_1s, set_pulse, add_pulse, add_level;
   logic [2:0] cur_inc, alm_inc, flash, mode;
   logic       carry_en, show_alarm;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   set_mode_controller #(
      .CLK_HZ        (50_000_000),
      .TIMEOUT_S     (TMO),
      .REPEAT_DELAY  (RD),
      .REPEAT_PERIOD (RP)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .tick_1s    (tick_1s),
      .set_pulse  (set_pulse),
      .add_pulse  (add_pulse),
      .add_level  (add_level),
      .cur_inc    (cur_inc),
      .alm_inc    (alm_inc),
      .carry_en   (carry_en),
      .show_alarm (show_alarm),
      .flash      (flash),
      .mode       (mode)
   );

   // Behavioural model: mode as an integer 0..6, idle tick count, press time of the hold
   int         m_mode = 0;
   int         m_idle = 0;
   int         m_cyc  = 0;
   int         m_t0   = 0;
   bit         m_armed = 1'b0;
   bit         m_valid = 1'b0;
   logic [2:0] e_cur, e_alm, e_flash;
   logic       e_carry, e_show;

   always @(posedge clk) begin
      int nm;
      int k;
      bit rpt;
      bit act;
      m_cyc++;
      if (rst) begin
         m_mode  = 0;
         m_idle  = 0;
         m_armed = 1'b0;
         e_cur   = 3'b000;
         e_alm   = 3'b000;
         e_flash = 3'b000;
         e_carry = 1'b1;
         e_show  = 1'b0;
         m_valid = 1'b1;
      end else begin
         k   = m_cyc - m_t0;
         rpt = RPT_EN && m_armed && add_level && !add_pulse && (k >= int'(RD))
               && ((k - int'(RD)) % int'(RP) == 0);
         act = (m_mode != 0) && (add_pulse || rpt);
         nm  = m_mode;
         e_cur = 3'b000;
         e_alm = 3'b000;
         if (m_mode == 0) begin
            if (tick_1s) e_cur = 3'b001;
            if (set_pulse && !add_pulse) nm = 1;
         end else if (act) begin
            if (m_mode <= 3) e_cur = 3'(1 << ((m_mode - 1) % 3));
            else             e_alm = 3'(1 << ((m_mode - 1) % 3));
            m_idle = 0;
         end else if (set_pulse) begin
            nm = (m_mode + 1) % 7;
         end else if (tick_1s) begin
            if (m_idle == int'(TMO)) nm = 0;
            else                     m_idle++;
         end
         if (nm != m_mode || m_mode == 0) begin
            m_armed = 1'b0;
         end else if (add_pulse) begin
            m_armed = 1'b1;
            m_t0    = m_cyc;
         end else if (m_armed && !add_level) begin
            m_armed = 1'b0;
         end
         if (nm != m_mode || nm == 0) m_idle = 0;
         m_mode  = nm;
         e_show  = (nm >= 4);
         e_flash = (nm == 0) ? 3'b000 : 3'(1 << ((nm - 1) % 3));
         e_carry = (nm == 0);
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (m_valid) begin
         checks++;
         if ({mode, cur_inc, alm_inc, flash, carry_en, show_alarm} !==
             {3'(m_mode), e_cur, e_alm, e_flash, e_carry, e_show}) begin
            errors++;
            $display("FAIL model t=%0t got mode=%0d cur=%b alm=%b flash=%b carry=%b show=%b, want mode=%0d cur=%b alm=%b flash=%b carry=%b show=%b",
                     $time, mode, cur_inc, alm_inc, flash, carry_en, show_alarm,
                     m_mode, e_cur, e_alm, e_flash, e_carry, e_show);
         end
      end
   end

   task automatic pin(input string name, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, got, exp);
      end
   endtask

   // Drive one cycle of pulses starting at a negedge, return at the next negedge
   task automatic cyc(input bit t, input bit s, input bit a);
      tick_1s   = t;
      set_pulse = s;
      add_pulse = a;
      @(negedge clk);
      tick_1s   = 1'b0;
      set_pulse = 1'b0;
      add_pulse = 1'b0;
   endtask

   initial begin
      int n;
      rst       = 1'b1;
      tick_1s   = 1'b0;
      set_pulse = 1'b0;
      add_pulse = 1'b0;
      add_level = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      pin("reset mode", 8'(mode), 8'd0);
      pin("reset carry", 8'(carry_en), 8'd1);
      pin("reset strobes", 8'({cur_inc, alm_inc}), 8'd0);
      pin("reset show/flash", 8'({show_alarm, flash}), 8'd0);

      // RUN: each tick gives one cur sec strobe a cycle later
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b0, 1'b0);
         pin("run tick strobe", 8'(cur_inc), 8'b001);
         cyc(1'b0, 1'b0, 1'b0);
         pin("run strobe width", 8'(cur_inc), 8'd0);
      end
      pin("run carry/flash", 8'({carry_en, flash}), 8'b1000);

      for (int i = 1; i <= 4; i++) begin
         cyc(1'b0, 1'b1, 1'b0);
         pin("set step mode", 8'(mode), 8'(i));
      end
      pin("alm sec show/flash", 8'({show_alarm, flash}), 8'b1001);
      pin("alm sec carry", 8'(carry_en), 8'd0);
      cyc(1'b0, 1'b0, 1'b1);
      pin("alm add strobe", 8'({cur_inc, alm_inc}), 8'b000001);
      cyc(1'b1, 1'b0, 1'b0);
      pin("alm tick frozen", 8'({cur_inc, alm_inc}), 8'd0);

      repeat (3) cyc(1'b0, 1'b1, 1'b0);
      pin("wrap to run", 8'(mode), 8'd0);
      repeat (7) cyc(1'b0, 1'b1, 1'b0);
      pin("seven sets wrap", 8'(mode), 8'd0);

      repeat (2) cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b1);
      pin("set+add strobe", 8'(cur_inc), 8'b010);
      pin("set+add mode", 8'(mode), 8'd2);

      // Timeout in CUR_HOUR: forced to RUN on the 4th idle tick
      cyc(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b0, 1'b0);
         repeat (2) cyc(1'b0, 1'b0, 1'b0);
      end
      pin("before timeout", 8'(mode), 8'd3);
      cyc(1'b1, 1'b0, 1'b0);
      pin("timeout mode", 8'(mode), 8'd0);
      pin("timeout no strobe", 8'(cur_inc), 8'd0);

      // Same, with an add after tick 2
      repeat (3) cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1);
      pin("hour add strobe", 8'(cur_inc), 8'b100);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      pin("timeout cleared by add", 8'(mode), 8'd3);

      // Hold add in CUR_SEC for 30 cycles after the press
      repeat (5) cyc(1'b0, 1'b1, 1'b0);
      pin("back to cur sec", 8'(mode), 8'd1);
      add_level = 1'b1;
      cyc(1'b0, 1'b0, 1'b1);
      n = int'(cur_inc[0]);
      for (int i = 1; i <= 35; i++) begin
         if (i == 31) add_level = 1'b0;
         cyc(1'b0, 1'b0, 1'b0);
         n += int'(cur_inc[0]);
      end
      pin("hold strobe count", 8'(n), 8'(HOLD_STROBES));

      // Reset while a repeat strobe is pending in ALM_MIN
      repeat (4) cyc(1'b0, 1'b1, 1'b0);
      pin("alm min mode", 8'(mode), 8'd5);
      add_level = 1'b1;
      cyc(1'b0, 1'b0, 1'b1);
      repeat (13) cyc(1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      pin("mid-repeat reset mode", 8'(mode), 8'd0);
      pin("mid-repeat reset strobes", 8'({cur_inc, alm_inc}), 8'd0);
      pin("mid-repeat reset show/carry", 8'({show_alarm, carry_en}), 8'b01);
      rst       = 1'b0;
      add_level = 1'b0;
      repeat (3) cyc(1'b0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
